mux2to1: RTL and testbench
==========================

// Module: mux2to1
// PURPOSE
//   32-bit two-input word selector for the RISC-V datapath, e.g. ALU operand B or write-back source.
//   OUT is purely combinational: it reflects IN0 when SEL=0 and IN1 when SEL=1, with zero cycles of latency.
//   A registered copy (OUT_R, SEL_R) serves timing-critical consumers such as the cache address path.
//   OUT_CHG flags that the registered copy moved on its last update.
// PARAMETERS
//   WIDTH      32   data width of IN0, IN1, OUT and OUT_R
//   RESET_VAL  0    value loaded into OUT_R during reset
// PORTS
//   CLK      in   1      single clock, rising-edge active
//   RST_N    in   1      reset, asynchronous assert, active-low
//   IN0      in   WIDTH  data input, selected when SEL=0
//   IN1      in   WIDTH  data input, selected when SEL=1
//   SEL      in   1      select: 0 -> IN0, 1 -> IN1
//   OUT      out  WIDTH  combinational selected word
//   OUT_R    out  WIDTH  registered copy of OUT
//   SEL_R    out  1      registered copy of SEL
//   OUT_CHG  out  1      1 for one cycle when OUT_R changed on the previous clock edge
// Interface: one clock; reset is asynchronous and active-low.
// BEHAVIOUR
//   OUT = SEL ? IN1 : IN0.
//     - Continuous and combinational; no clock or reset dependency.
//     - Valid even while RST_N=0 and with CLK stopped.
//   SEL = X or Z: OUT is driven to all-X in simulation. Never latch a stale value.
//   Reset (RST_N=0, applied asynchronously):
//     - OUT_R  = RESET_VAL
//     - SEL_R  = 0
//     - OUT_CHG = 0
//   Reset release: registers update from the first rising CLK edge with RST_N=1.
//   Each rising CLK edge with RST_N=1:
//     - OUT_R <= OUT
//     - SEL_R <= SEL
//     - OUT_CHG <= (OUT != OUT_R)
//   Registered-path latency is exactly 1 cycle. There is no enable and no handshake.
//   Reset asserted mid-operation: registers clear immediately, independent of CLK. OUT is unaffected.
//   IN0 == IN1: OUT and OUT_R are independent of SEL.
//     - A SEL toggle alone must not raise OUT_CHG.
//   All widths are exactly WIDTH: no sign extension, truncation or arithmetic.
//   No latches. Every combinational assignment is complete for both SEL values.
// STRUCTURE
//   Package mux_pkg:
//     - XLEN = 32 (default for WIDTH)
//     - typedef logic [XLEN-1:0] word_t
//   Sub-module mux2_comb: the pure combinational select, instantiated once, reusable elsewhere.
//   Top level holds the three registers and the change comparator.
// TESTING
//   1. IN0=5, IN1=10, SEL=0 -> OUT=5. Then SEL=1 -> OUT=10 (check 5 time units after each change, no clock).
//   2. IN0=32'hFFFF_FFFF, IN1=10:
//      - SEL=0 -> OUT=32'hFFFF_FFFF
//      - SEL=1 -> OUT=10
//      - all 32 bits checked
//   3. IN0=IN1=10, SEL 0->1 -> OUT stays 10. With clock running, OUT_CHG stays 0.
//   4. IN0=0, IN1=10, SEL=0 -> OUT=0. After one CLK edge: OUT_R=0, SEL_R=0.
//   5. Clocked run, IN0=5, IN1=10, SEL 0->1:
//      - OUT=10 immediately
//      - OUT_R=10 and OUT_CHG=1 after the next edge
//      - OUT_CHG=0 one edge later
//   6. RST_N pulled low between clock edges with OUT_R=10:
//      - OUT_R=0, SEL_R=0, OUT_CHG=0 immediately
//      - OUT still tracks SEL

Source files
------------

// File: rtl/mux_pkg.sv
// Shared datapath types for the word selectors.
// XLEN sets the default word width.
package mux_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/mux2_comb.sv
// Pure combinational two-way word select.
// An unknown select yields an all-X word.
module mux2_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    unique case (sel)
      1'b0:    y = in0;
      1'b1:    y = in1;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux2to1.sv
// Word selector with a registered copy and change flag.
// out is combinational; out_r/sel_r/out_chg are 1-cycle registered.
module mux2to1
  import mux_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_r,
  output logic             sel_r,
  output logic             out_chg
);

  mux2_comb #(
    .WIDTH(WIDTH)
  ) u_sel (
    .in0(in0),
    .in1(in1),
    .sel(sel),
    .y  (out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r   <= RESET_VAL;
      sel_r   <= 1'b0;
      out_chg <= 1'b0;
    end else begin
      out_r   <= out;
      sel_r   <= sel;
      out_chg <= (out != out_r);
    end
  end

endmodule

// File: tb/tb_mux2to1.sv
// Randomized and directed bench for mux2to1.
// Outputs compared to a behavioural model at each falling edge.
module tb_mux2to1;
  import mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        chk_en = 1'b0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        sel = 1'b0;
  logic [31:0] out;
  logic [31:0] out_r;
  logic        sel_r;
  logic        out_chg;

  int n_chk = 0;
  int n_fail = 0;

  mux2to1 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in0    (in0),
    .in1    (in1),
    .sel    (sel),
    .out    (out),
    .out_r  (out_r),
    .sel_r  (sel_r),
    .out_chg(out_chg)
  );

  initial forever begin
    #5;
    if (run) clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the registered view is the word seen at the last edge
  logic [31:0] m_r = '0;
  logic        m_sel = 1'b0;
  logic        m_chg = 1'b0;

  always @(negedge rst_n) begin
    m_r = '0;
    m_sel = 1'b0;
    m_chg = 1'b0;
  end

  always @(posedge clk) begin
    logic [31:0] w;
    if (rst_n) begin
      w = sel ? in1 : in0;
      m_chg = (w != m_r);
      m_r = w;
      m_sel = sel;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out", out, sel ? in1 : in0);
      chk("model_out_r", out_r, m_r);
      chk("model_sel_r", {31'b0, sel_r}, {31'b0, m_sel});
      chk("model_chg", {31'b0, out_chg}, {31'b0, m_chg});
    end
  end

  task automatic mid();
    @(negedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] pool [4];

    // Combinational select with clock stopped and reset held
    in0 = 32'd5; in1 = 32'd10; sel = 1'b0;
    #5 chk("t1_sel0", out, 32'd5);
    chk("rst_out_r", out_r, 32'd0);
    chk("rst_sel_r", {31'b0, sel_r}, 32'd0);
    chk("rst_chg", {31'b0, out_chg}, 32'd0);
    sel = 1'b1;
    #5 chk("t1_sel1", out, 32'd10);

    in0 = 32'hFFFF_FFFF; in1 = 32'd10; sel = 1'b0;
    #5 chk("t2_sel0", out, 32'hFFFF_FFFF);
    sel = 1'b1;
    #5 chk("t2_sel1", out, 32'd10);

    // Start clocking
    in0 = 32'd0; in1 = 32'd10; sel = 1'b0;
    #5 chk("t4_out", out, 32'd0);
    rst_n = 1'b1;
    #1 run = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("t4_out_r", out_r, 32'd0);
    chk("t4_sel_r", {31'b0, sel_r}, 32'd0);

    // Equal inputs: select toggles must not flag a change
    #2 in0 = 32'd10; in1 = 32'd10;
    mid();
    mid();
    for (int i = 0; i < 4; i++) begin
      sel = ~sel;
      #1 chk("t3_out", out, 32'd10);
      @(negedge clk);
      chk("t3_chg", {31'b0, out_chg}, 32'd0);
      #2;
    end

    in0 = 32'd5; in1 = 32'd10; sel = 1'b0;
    mid();
    mid();
    sel = 1'b1;
    #1 chk("t5_out_now", out, 32'd10);
    @(negedge clk);
    chk("t5_out_r", out_r, 32'd10);
    chk("t5_chg1", {31'b0, out_chg}, 32'd1);
    @(negedge clk);
    chk("t5_chg0", {31'b0, out_chg}, 32'd0);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 chk("t6_out_r", out_r, 32'd0);
    chk("t6_sel_r", {31'b0, sel_r}, 32'd0);
    chk("t6_chg", {31'b0, out_chg}, 32'd0);
    chk("t6_out1", out, 32'd10);
    sel = 1'b0;
    #1 chk("t6_out0", out, 32'd5);
    mid();
    rst_n = 1'b1;

    pool[0] = 32'h0000_0000;
    pool[1] = 32'hFFFF_FFFF;
    pool[2] = 32'hA5A5_5A5A;
    pool[3] = 32'h0000_000A;
    for (int i = 0; i < 400; i++) begin
      mid();
      if ($urandom_range(0, 3) == 0) begin
        in0 = pool[$urandom_range(0, 3)];
        in1 = pool[$urandom_range(0, 3)];
      end else begin
        in0 = $urandom;
        in1 = ($urandom_range(0, 4) == 0) ? in0 : $urandom;
      end
      sel = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
